// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared constants for the GPIO port controller: the default bank width and
// the 3-bit register addresses decoded by the register bus.
// No ports; imported by the interface, the synchroniser and the top.
// -----------------------------------------------------------------------------
package gpio_pkg;

  // Default number of pads in one bank (also the register data width).
  localparam int GPIO_N_PINS = 8;

  // Width of the register index on the bus.
  localparam int GPIO_ADDR_W = 3;

  // Register map.
  localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR  = 3'd0;  // RW  1 = output
  localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT  = 3'd1;  // RW  output value
  localparam logic [GPIO_ADDR_W-1:0] GPIO_PU   = 3'd2;  // RW  pull-up enable
  localparam logic [GPIO_ADDR_W-1:0] GPIO_PD   = 3'd3;  // RW  pull-down enable
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IN   = 3'd4;  // RO  synchronised pad_y
  localparam logic [GPIO_ADDR_W-1:0] GPIO_RISE = 3'd5;  // RW  rising-edge irq enable
  localparam logic [GPIO_ADDR_W-1:0] GPIO_FALL = 3'd6;  // RW  falling-edge irq enable
  localparam logic [GPIO_ADDR_W-1:0] GPIO_STAT = 3'd7;  // W1C edge flags

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// gpio_port_ctrl_if
// Single-cycle register bus between the SPI slave front end (master) and the
// GPIO port controller (slave).
//   reg_wr     write strobe, one cycle per write
//   reg_rd     read strobe, one cycle per read
//   reg_addr   register index
//   reg_wdata  write data
//   reg_rdata  read data, registered, held while reg_rvalid is low
//   reg_rvalid one-cycle pulse the cycle after reg_rd
// -----------------------------------------------------------------------------
interface gpio_port_ctrl_if
  import gpio_pkg::*;
#(
  parameter int N_PINS = GPIO_N_PINS
);

  logic                   reg_wr;
  logic                   reg_rd;
  logic [GPIO_ADDR_W-1:0] reg_addr;
  logic [N_PINS-1:0]      reg_wdata;
  logic [N_PINS-1:0]      reg_rdata;
  logic                   reg_rvalid;

  // Bus requester side (SPI front end or testbench).
  modport master (
    output reg_wr,
    output reg_rd,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata,
    input  reg_rvalid
  );

  // Register file side (the port controller).
  modport slave (
    input  reg_wr,
    input  reg_rd,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata,
    output reg_rvalid
  );

endinterface

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// N-bit multi-flop synchroniser for asynchronous pad receiver outputs.
// Each bit passes through STAGES flops; all flops clear on async reset.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d_i    in   asynchronous input vector
//   q_o    out  synchronised vector (output of the last stage)
// -----------------------------------------------------------------------------
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int N      = GPIO_N_PINS,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] stage_q [STAGES];

  // Shift chain: stage 0 captures the raw pad, later stages settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_port_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_port_ctrl
// Core-side controller for one bank of GPIO pads. Holds the register file,
// drives pad controls, synchronises pad inputs, detects enabled edges into a
// sticky W1C status register and raises a registered level interrupt.
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   bus     slave register bus (wr/rd strobes, addr, wdata, rdata, rvalid)
//   pad_a   out  per-pad output value   (OUT & DIR)
//   pad_oe  out  per-pad driver enable  (DIR)
//   pad_pu  out  per-pad pull-up        (PU & ~PD)
//   pad_pd  out  per-pad pull-down      (PD)
//   pad_y   in   per-pad receiver output, asynchronous to clk
//   irq     out  level interrupt, |STAT delayed by one cycle
// -----------------------------------------------------------------------------
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int N_PINS      = GPIO_N_PINS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_port_ctrl_if.slave   bus,
  output logic [N_PINS-1:0] pad_a,
  output logic [N_PINS-1:0] pad_oe,
  output logic [N_PINS-1:0] pad_pu,
  output logic [N_PINS-1:0] pad_pd,
  input  logic [N_PINS-1:0] pad_y,
  output logic              irq
);

  // Arming counter counts 0 .. SYNC_STAGES+1 and then sticks.
  localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0]  ARM_ONE  = ARM_W'(1);

  // Register file.
  logic [N_PINS-1:0] dir_q,  dir_d;
  logic [N_PINS-1:0] out_q,  out_d;
  logic [N_PINS-1:0] pu_q,   pu_d;
  logic [N_PINS-1:0] pd_q,   pd_d;
  logic [N_PINS-1:0] rise_q, rise_d;
  logic [N_PINS-1:0] fall_q, fall_d;
  logic [N_PINS-1:0] stat_q, stat_d;

  // Input path and edge detection.
  logic [N_PINS-1:0] in_s;
  logic [N_PINS-1:0] prev_q;
  logic [N_PINS-1:0] rise_s;
  logic [N_PINS-1:0] fall_s;
  logic [N_PINS-1:0] set_s;
  logic [N_PINS-1:0] w1c_s;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic              armed_s;

  // Read path and interrupt.
  logic [N_PINS-1:0] rd_mux_s;
  logic [N_PINS-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              irq_q, irq_d;

  gpio_sync #(
    .N      (N_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pad_y),
    .q_o   (in_s)
  );

  // Pad controls follow the registers directly; PD masks PU so the pad never
  // sees both pulls at once.
  assign pad_oe = dir_q;
  assign pad_a  = out_q & dir_q;
  assign pad_pd = pd_q;
  assign pad_pu = pu_q & ~pd_q;

  assign bus.reg_rdata  = rdata_q;
  assign bus.reg_rvalid = rvalid_q;
  assign irq            = irq_q;

  // Write decode: one register updated per strobe; STAT writes become a clear mask.
  always_comb begin
    dir_d  = dir_q;
    out_d  = out_q;
    pu_d   = pu_q;
    pd_d   = pd_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c_s  = '0;
    if (bus.reg_wr) begin
      case (bus.reg_addr)
        GPIO_DIR:  dir_d  = bus.reg_wdata;
        GPIO_OUT:  out_d  = bus.reg_wdata;
        GPIO_PU:   pu_d   = bus.reg_wdata;
        GPIO_PD:   pd_d   = bus.reg_wdata;
        GPIO_IN:   dir_d  = dir_q;          // read-only, write has no effect
        GPIO_RISE: rise_d = bus.reg_wdata;
        GPIO_FALL: fall_d = bus.reg_wdata;
        GPIO_STAT: w1c_s  = bus.reg_wdata;
        default:   dir_d  = dir_q;
      endcase
    end else begin
      w1c_s = '0;
    end
  end

  // Arming and edge detection. The synchroniser fills from 0 after reset, which
  // would look like rising edges; detection stays masked until the pipeline
  // (SYNC_STAGES flops plus prev) has been refilled.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    armed_s   = (arm_cnt_q == ARM_DONE);
    rise_s    = in_s & ~prev_q & rise_q;
    fall_s    = ~in_s & prev_q & fall_q;
    if (armed_s) begin
      set_s = rise_s | fall_s;
    end else begin
      set_s     = '0;
      arm_cnt_d = arm_cnt_q + ARM_ONE;
    end
    // Clear first, then set, so a new edge in the clearing cycle survives.
    stat_d = (stat_q & ~w1c_s) | set_s;
    irq_d  = |stat_q;
  end

  // Read mux samples the pre-write register values; rdata holds between reads.
  always_comb begin
    rd_mux_s = '0;
    case (bus.reg_addr)
      GPIO_DIR:  rd_mux_s = dir_q;
      GPIO_OUT:  rd_mux_s = out_q;
      GPIO_PU:   rd_mux_s = pu_q;
      GPIO_PD:   rd_mux_s = pd_q;
      GPIO_IN:   rd_mux_s = in_s;
      GPIO_RISE: rd_mux_s = rise_q;
      GPIO_FALL: rd_mux_s = fall_q;
      GPIO_STAT: rd_mux_s = stat_q;
      default:   rd_mux_s = '0;
    endcase
    rvalid_d = bus.reg_rd;
    if (bus.reg_rd) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; reset clears everything, including any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q     <= '0;
      out_q     <= '0;
      pu_q      <= '0;
      pd_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      stat_q    <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      pu_q      <= pu_d;
      pd_q      <= pd_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stat_q    <= stat_d;
      prev_q    <= in_s;
      arm_cnt_q <= arm_cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_port_ctrl
// Self-checking bench for gpio_port_ctrl. Read expectations are pushed to a
// queue when reg_rd is driven and popped by a monitor when reg_rvalid pulses.
// -----------------------------------------------------------------------------
module tb_gpio_port_ctrl;
  import gpio_pkg::*;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pad_a, pad_oe, pad_pu, pad_pd;
  logic [N-1:0] pad_y;
  logic         irq;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] exp_q [$];
  logic         exp_rv = 1'b0;

  gpio_port_ctrl_if #(.N_PINS(N)) bus ();

  gpio_port_ctrl #(
    .N_PINS      (N),
    .SYNC_STAGES (S)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pad_a  (pad_a),
    .pad_oe (pad_oe),
    .pad_pu (pad_pu),
    .pad_pd (pad_pd),
    .pad_y  (pad_y),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // A read sampled at this edge must produce rvalid in the following cycle.
  always @(posedge clk) exp_rv <= rst_n & bus.reg_rd;

  // Scoreboard: compare rvalid timing and rdata against the queued expectation.
  always @(negedge clk) begin
    if (exp_rv || bus.reg_rvalid) begin
      checks++;
      if (bus.reg_rvalid !== exp_rv) begin
        errors++;
        $display("FAIL rvalid_timing: got %b expected %b", bus.reg_rvalid, exp_rv);
      end
      if (exp_rv) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rdata_queue: got empty queue expected an entry");
        end else begin
          if (bus.reg_rvalid === 1'b1) begin
            checks++;
            if (bus.reg_rdata !== exp_q[0]) begin
              errors++;
              $display("FAIL rdata: got %h expected %h", bus.reg_rdata, exp_q[0]);
            end
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [N-1:0] d);
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_wr    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [N-1:0] e);
    bus.reg_rd   = 1'b1;
    bus.reg_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    bus.reg_rd   = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({pad_a, pad_oe, pad_pu, pad_pd} !== 32'h0) begin
      errors++;
      $display("FAIL reset_pads: got %h expected %h", {pad_a, pad_oe, pad_pu, pad_pd}, 32'h0);
    end
    checks++;
    if ({irq, bus.reg_rvalid, bus.reg_rdata} !== 10'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected %h", {irq, bus.reg_rvalid, bus.reg_rdata}, 10'h0);
    end
    rst_n = 1'b1;
    cyc(1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 8'h00);
    end
    cyc(2);
    checks++;
    if ({pad_oe, pad_pu, pad_pd} !== 24'h0) begin
      errors++;
      $display("FAIL reset_pads_after: got %h expected %h", {pad_oe, pad_pu, pad_pd}, 24'h0);
    end
  endtask

  task automatic test_pad_ctrl;
    wr(GPIO_DIR, 8'h0F);
    wr(GPIO_OUT, 8'hA5);
    checks++;
    if (pad_oe !== 8'h0F) begin
      errors++;
      $display("FAIL pad_oe: got %h expected %h", pad_oe, 8'h0F);
    end
    checks++;
    if (pad_a !== 8'h05) begin
      errors++;
      $display("FAIL pad_a: got %h expected %h", pad_a, 8'h05);
    end
    wr(GPIO_PU, 8'hFF);
    wr(GPIO_PD, 8'h30);
    checks++;
    if (pad_pu !== 8'hCF) begin
      errors++;
      $display("FAIL pad_pu: got %h expected %h", pad_pu, 8'hCF);
    end
    checks++;
    if (pad_pd !== 8'h30) begin
      errors++;
      $display("FAIL pad_pd: got %h expected %h", pad_pd, 8'h30);
    end
    rd(GPIO_DIR, 8'h0F);
    rd(GPIO_OUT, 8'hA5);
    rd(GPIO_PU,  8'hFF);
    rd(GPIO_PD,  8'h30);
    cyc(2);
    checks++;
    if ({bus.reg_rvalid, bus.reg_rdata} !== 9'h030) begin
      errors++;
      $display("FAIL rdata_hold: got %h expected %h", {bus.reg_rvalid, bus.reg_rdata}, 9'h030);
    end
    // Loopback sampling of the pads and write-ignore on IN.
    pad_y = 8'h5A;
    cyc(S + 1);
    rd(GPIO_IN, 8'h5A);
    wr(GPIO_IN, 8'hFF);
    rd(GPIO_IN, 8'h5A);
    // Same-cycle write and read of DIR returns the old value.
    bus.reg_wr    = 1'b1;
    bus.reg_rd    = 1'b1;
    bus.reg_addr  = GPIO_DIR;
    bus.reg_wdata = 8'hF0;
    exp_q.push_back(8'h0F);
    @(negedge clk);
    bus.reg_wr = 1'b0;
    bus.reg_rd = 1'b0;
    rd(GPIO_DIR, 8'hF0);
    checks++;
    if ({pad_oe, pad_a} !== 16'hF0A0) begin
      errors++;
      $display("FAIL pad_after_rmw: got %h expected %h", {pad_oe, pad_a}, 16'hF0A0);
    end
    pad_y = 8'h00;
    cyc(S + 2);
    rd(GPIO_STAT, 8'h00);
  endtask

  task automatic test_edge_rise;
    wr(GPIO_RISE, 8'h01);
    pad_y[0] = 1'b1;
    cyc(2);
    rd(GPIO_STAT, 8'h00);   // sampled on the third edge, before the flag lands
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_lag: got %b expected %b", irq, 1'b0);
    end
    rd(GPIO_STAT, 8'h01);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b expected %b", irq, 1'b1);
    end
    wr(GPIO_STAT, 8'h01);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_clear_lag: got %b expected %b", irq, 1'b1);
    end
    cyc(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b expected %b", irq, 1'b0);
    end
    rd(GPIO_STAT, 8'h00);
    pad_y[0] = 1'b0;        // falling edge not enabled on pin 0
    cyc(S + 2);
    rd(GPIO_STAT, 8'h00);
  endtask

  task automatic test_arming;
    pad_y = 8'h80;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    wr(GPIO_RISE, 8'h80);   // enabled before the fill-induced rise reaches edge detect
    wr(GPIO_FALL, 8'h80);
    cyc(3);
    rd(GPIO_STAT, 8'h00);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_arming: got %b expected %b", irq, 1'b0);
    end
    pad_y[7] = 1'b0;
    cyc(S + 1);
    rd(GPIO_STAT, 8'h80);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_fall: got %b expected %b", irq, 1'b1);
    end
    wr(GPIO_STAT, 8'h80);
    cyc(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_fall_clear: got %b expected %b", irq, 1'b0);
    end
    rd(GPIO_STAT, 8'h00);
  endtask

  task automatic test_set_w1c_collision;
    wr(GPIO_RISE, 8'h01);
    pad_y[0] = 1'b1;
    cyc(S + 1);
    rd(GPIO_STAT, 8'h01);
    pad_y[0] = 1'b0;
    cyc(S + 2);
    pad_y[0] = 1'b1;
    cyc(2);
    wr(GPIO_STAT, 8'h01);   // clear lands on the same edge as the new rise
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_collision: got %b expected %b", irq, 1'b1);
    end
    rd(GPIO_STAT, 8'h01);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_collision_hold: got %b expected %b", irq, 1'b1);
    end
    wr(GPIO_STAT, 8'h01);
    cyc(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_collision_clear: got %b expected %b", irq, 1'b0);
    end
    rd(GPIO_STAT, 8'h00);
  endtask

  task automatic test_reset_midop;
    wr(GPIO_RISE, 8'hFF);
    wr(GPIO_FALL, 8'hFF);
    pad_y = ~pad_y;         // every pin sees one edge
    cyc(S + 1);
    rd(GPIO_STAT, 8'hFF);
    wr(GPIO_DIR, 8'hFF);
    wr(GPIO_OUT, 8'hFF);
    wr(GPIO_PU,  8'h0F);
    wr(GPIO_PD,  8'hF0);
    checks++;
    if ({pad_a, pad_oe, pad_pu, pad_pd, irq} !== 33'h1_FFFF_0FF0 >> 0 && {pad_a, pad_oe, pad_pu, pad_pd, irq} !== {8'hFF, 8'hFF, 8'h0F, 8'hF0, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_outs: got %h expected %h", {pad_a, pad_oe, pad_pu, pad_pd, irq}, {8'hFF, 8'hFF, 8'h0F, 8'hF0, 1'b1});
    end
    bus.reg_rd   = 1'b1;    // read pending when reset hits; no expectation queued
    bus.reg_addr = GPIO_STAT;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pad_a, pad_oe, pad_pu, pad_pd} !== 32'h0) begin
      errors++;
      $display("FAIL midreset_pads: got %h expected %h", {pad_a, pad_oe, pad_pu, pad_pd}, 32'h0);
    end
    checks++;
    if ({irq, bus.reg_rvalid, bus.reg_rdata} !== 10'h0) begin
      errors++;
      $display("FAIL midreset_outs: got %h expected %h", {irq, bus.reg_rvalid, bus.reg_rdata}, 10'h0);
    end
    @(negedge clk);
    bus.reg_rd = 1'b0;
    rst_n      = 1'b1;
    checks++;
    if ({bus.reg_rvalid, bus.reg_rdata} !== 9'h0) begin
      errors++;
      $display("FAIL dropped_read: got %h expected %h", {bus.reg_rvalid, bus.reg_rdata}, 9'h0);
    end
    cyc(1);
    checks++;
    if (bus.reg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL dropped_read_late: got %b expected %b", bus.reg_rvalid, 1'b0);
    end
    cyc(S + 1);
    rd(GPIO_IN,   8'hFE);
    rd(GPIO_STAT, 8'h00);
    rd(GPIO_DIR,  8'h00);
    rd(GPIO_RISE, 8'h00);
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.reg_wr    = 1'b0;
    bus.reg_rd    = 1'b0;
    bus.reg_addr  = 3'd0;
    bus.reg_wdata = 8'h00;
    pad_y         = 8'h00;
    rst_n         = 1'b0;
    cyc(3);
    test_reset();
    test_pad_ctrl();
    test_edge_rise();
    test_arming();
    test_set_w1c_collision();
    test_reset_midop();
    cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reads_outstanding: got %0d expected %0d", exp_q.size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
